// File: rtl/camera_pkg.sv
// Shared types and default frame geometry for the camera capture controller.
package camera_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } capture_state_t;

  localparam int DEF_H_ACTIVE = 320;
  localparam int DEF_V_ACTIVE = 240;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

endpackage

// File: rtl/rise_fall_det.sv
// Edge detector: compares the live input against its registered copy.
module rise_fall_det (
  input  logic p_clock_in,
  input  logic rst_in,
  input  logic sig,
  output logic rise,
  output logic fall
);

  logic sig_q;

  always_ff @(posedge p_clock_in or posedge rst_in) begin
    if (rst_in) sig_q <= 1'b0;
    else        sig_q <= sig;
  end

  assign rise = sig & ~sig_q;
  assign fall = ~sig & sig_q;

endmodule

// File: rtl/camera_capture_ctrl.sv
// Single-frame camera capture sequencer: pixel stream -> frame-buffer BRAM writes.
// Define CAPTURE_CONT_EN for continuous capture (DONE re-arms instead of idling).
//
// state   | meaning
// IDLE    | waiting for a capture request rising edge
// ARMED   | waiting for vsync high-then-low (frame boundary)
// CAPTURE | writing pixels, tracking rows via href falls
// DONE    | one-cycle completion pulse
module camera_capture_ctrl
  import camera_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int ADDR_W   = 17
) (
  input  logic              p_clock_in,
  input  logic              rst_in,
  input  logic              capture_req_in,
  input  logic              vsync_in,
  input  logic              href_in,
  input  logic              pixel_valid_in,
  input  logic [15:0]       pixel_data_in,
  output logic [ADDR_W-1:0] bram_addr_out,
  output logic [15:0]       bram_data_out,
  output logic              bram_we_out,
  output logic              busy_out,
  output logic              capture_done_out,
  output logic              short_frame_out
);

  localparam int XW = $clog2(H_ACTIVE + 1);
  localparam int YW = $clog2(V_ACTIVE + 1);
  localparam logic [XW-1:0]     X_LIM    = XW'(H_ACTIVE);
  localparam logic [YW-1:0]     Y_LIM    = YW'(V_ACTIVE);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(H_ACTIVE);

  capture_state_t state, state_nxt;

  logic req_rise, req_fall, vsync_rise, vsync_fall, href_rise, href_fall;
  logic unused_edges;

  logic [XW-1:0]     x;
  logic [YW-1:0]     y;
  logic [ADDR_W-1:0] addr, row_base;
  rgb565_t           pix_q;
  logic              start, accept, row_adv, enter_armed;

  rise_fall_det u_req_det (
    .p_clock_in(p_clock_in), .rst_in(rst_in), .sig(capture_req_in),
    .rise(req_rise), .fall(req_fall)
  );

  rise_fall_det u_vsync_det (
    .p_clock_in(p_clock_in), .rst_in(rst_in), .sig(vsync_in),
    .rise(vsync_rise), .fall(vsync_fall)
  );

  rise_fall_det u_href_det (
    .p_clock_in(p_clock_in), .rst_in(rst_in), .sig(href_in),
    .rise(href_rise), .fall(href_fall)
  );

  assign unused_edges = req_fall ^ href_rise;

  always_ff @(posedge p_clock_in or posedge rst_in) begin
    if (rst_in) state <= IDLE;
    else        state <= state_nxt;
  end

  // A vsync fall implies vsync was high the cycle before, including at arm time.
  always_comb begin
    state_nxt        = state;
    busy_out         = 1'b0;
    capture_done_out = 1'b0;
    case (state)
      IDLE: begin
        if (req_rise) state_nxt = ARMED;
      end
      ARMED: begin
        busy_out = 1'b1;
        if (vsync_fall) state_nxt = CAPTURE;
      end
      CAPTURE: begin
        busy_out = 1'b1;
        if (vsync_rise) state_nxt = DONE;
      end
      DONE: begin
        capture_done_out = 1'b1;
`ifdef CAPTURE_CONT_EN
        state_nxt = ARMED;
`else
        state_nxt = IDLE;
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign start       = (state == ARMED) && vsync_fall;
  assign accept      = (state == CAPTURE) && pixel_valid_in && (x < X_LIM) && (y < Y_LIM);
  assign row_adv     = (state == CAPTURE) && href_fall && (x != '0);
  assign enter_armed = (state != ARMED) && (state_nxt == ARMED);

  // The write in the row-advance cycle uses the old addr; the counters move on afterwards.
  always_ff @(posedge p_clock_in or posedge rst_in) begin
    if (rst_in) begin
      x        <= '0;
      y        <= '0;
      addr     <= '0;
      row_base <= '0;
    end else if (start) begin
      x        <= '0;
      y        <= '0;
      addr     <= '0;
      row_base <= '0;
    end else if (row_adv) begin
      x        <= '0;
      if (y < Y_LIM) y <= y + YW'(1);
      row_base <= row_base + ROW_STEP;
      addr     <= row_base + ROW_STEP;
    end else if (accept) begin
      x    <= x + XW'(1);
      addr <= addr + ADDR_W'(1);
    end
  end

  always_ff @(posedge p_clock_in or posedge rst_in) begin
    if (rst_in) begin
      bram_we_out     <= 1'b0;
      bram_addr_out   <= '0;
      pix_q           <= '0;
      short_frame_out <= 1'b0;
    end else begin
      bram_we_out <= accept;
      if (accept) begin
        bram_addr_out <= addr;
        pix_q         <= rgb565_t'(pixel_data_in);
      end
      if (enter_armed)
        short_frame_out <= 1'b0;
      else if ((state == CAPTURE) && vsync_rise)
        short_frame_out <= (y < Y_LIM);
    end
  end

  assign bram_data_out = pix_q;

endmodule

// File: tb/tb_camera_capture_ctrl.sv
// Randomized self-checking bench for camera_capture_ctrl on a reduced frame size.
module tb_camera_capture_ctrl;

  localparam int H  = 20;
  localparam int V  = 12;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst, capture_req, vsync, href, pvalid;
  logic [15:0]   pdata;
  logic [AW-1:0] bram_addr;
  logic [15:0]   bram_data;
  logic          bram_we, busy, done, short_f;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  int busy_at_done = 0;
  bit model_on = 1'b0;
  logic [AW+15:0] exp_q[$];
  logic [AW+15:0] obs_q[$];

  always #5 clk = ~clk;

  camera_capture_ctrl #(.H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW)) dut (
    .p_clock_in(clk), .rst_in(rst), .capture_req_in(capture_req),
    .vsync_in(vsync), .href_in(href), .pixel_valid_in(pvalid),
    .pixel_data_in(pdata), .bram_addr_out(bram_addr), .bram_data_out(bram_data),
    .bram_we_out(bram_we), .busy_out(busy), .capture_done_out(done),
    .short_frame_out(short_f)
  );

  always @(negedge clk) begin
    if (!rst) begin
      if (bram_we) obs_q.push_back({bram_addr, bram_data});
      if (done) begin
        done_cnt++;
        if (busy) busy_at_done++;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation still running at 2ms (expected finish)");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_req();
    capture_req = 1'b1;
    tick();
    capture_req = 1'b0;
    tick();
  endtask

  // Model: pixel k of the r-th non-empty row lands at r*H+k when k<H and r<V.
  task automatic drive_row(input int n, inout int ry);
    bit fall_last;
    fall_last = ($urandom_range(0, 1) == 1);
    href = 1'b1;
    tick();
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(0, 2)) tick();
      pvalid = 1'b1;
      pdata  = 16'($urandom);
      if (model_on && k < H && ry < V) exp_q.push_back({AW'(ry * H + k), pdata});
      if (k == n - 1 && fall_last) href = 1'b0;
      tick();
      pvalid = 1'b0;
    end
    href = 1'b0;
    tick();
    tick();
    if (n > 0 && ry < V) ry++;
  endtask

  task automatic drive_frame(input int nrows, input int mode, input bit req_mid, output int ry);
    ry = 0;
    vsync = 1'b0;
    repeat (3) tick();
    for (int r = 0; r < nrows; r++) begin
      int n;
      case (mode)
        0:       n = H;
        1:       n = $urandom_range(H - 3, H + 10);
        default: n = (r % 2 == 0) ? $urandom_range(1, H + 5) : $urandom_range(0, H + 5);
      endcase
      if (req_mid && r == nrows / 2) capture_req = 1'b1;
      drive_row(n, ry);
      capture_req = 1'b0;
    end
    vsync = 1'b1;
  endtask

  task automatic wait_done(input string name, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      tick();
      if (done) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s done_wait: capture_done_out got 0 within 50 cycles, expected 1", name);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; capture_req = 1'b0; vsync = 1'b0; href = 1'b0; pvalid = 1'b0; pdata = '0;
    repeat (3) tick();
    checks++;
    if ({bram_we, busy, done, short_f} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: we/busy/done/short got %b expected 0000", {bram_we, busy, done, short_f});
    end
    checks++;
    if (bram_addr !== '0) begin
      errors++;
      $display("FAIL reset_addr: got %0d expected 0", bram_addr);
    end
    checks++;
    if (bram_data !== '0) begin
      errors++;
      $display("FAIL reset_data: got %h expected 0000", bram_data);
    end
    rst = 1'b0;
    repeat (2) tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle_busy: got %b expected 0", busy);
    end
  endtask

  task automatic test_full_frame();
    int ry, d0;
    bit seen;
    exp_q.delete(); obs_q.delete(); d0 = done_cnt; model_on = 1'b1;
    vsync = 1'b1;
    repeat (2) tick();
    pulse_req();
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL full_armed_busy: got %b expected 1", busy); end
    drive_frame(V, 0, 1'b0, ry);
    wait_done("full_frame", seen);
    repeat (3) tick();
    checks++;
    if (obs_q.size() != V * H || exp_q.size() != V * H) begin
      errors++;
      $display("FAIL full_write_count: got %0d expected %0d", obs_q.size(), V * H);
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL full_write[%0d]: got addr=%0d data=%h expected addr=%0d data=%h",
                 i, obs_q[i][AW+15:16], obs_q[i][15:0], exp_q[i][AW+15:16], exp_q[i][15:0]);
      end
    end
    checks++;
    if (done_cnt != d0 + 1) begin errors++; $display("FAIL full_done_count: got %0d expected %0d", done_cnt - d0, 1); end
    checks++;
    if (short_f !== 1'b0) begin errors++; $display("FAIL full_short: got %b expected 0", short_f); end
    checks++;
    if (busy !== 1'b0 || busy_at_done != 0) begin
      errors++;
      $display("FAIL full_busy: busy=%b busy_at_done=%0d expected 0 and 0", busy, busy_at_done);
    end
  endtask

  task automatic test_long_rows();
    int ry, d0;
    bit seen;
    exp_q.delete(); obs_q.delete(); d0 = done_cnt; model_on = 1'b1;
    pulse_req();
    drive_frame(V, 1, 1'b0, ry);
    wait_done("long_rows", seen);
    repeat (3) tick();
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL long_write_count: got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL long_write[%0d]: got addr=%0d data=%h expected addr=%0d data=%h",
                 i, obs_q[i][AW+15:16], obs_q[i][15:0], exp_q[i][AW+15:16], exp_q[i][15:0]);
      end
    end
    checks++;
    if (done_cnt != d0 + 1) begin errors++; $display("FAIL long_done_count: got %0d expected 1", done_cnt - d0); end
    checks++;
    if (short_f !== (ry < V)) begin errors++; $display("FAIL long_short: got %b expected %b", short_f, ry < V); end
  endtask

  task automatic test_short_frame();
    int ry, d0, last_exp;
    bit seen;
    exp_q.delete(); obs_q.delete(); d0 = done_cnt; model_on = 1'b1;
    pulse_req();
    drive_frame(5, 2, 1'b0, ry);
    wait_done("short_frame", seen);
    repeat (3) tick();
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL short_write_count: got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL short_write[%0d]: got addr=%0d data=%h expected addr=%0d data=%h",
                 i, obs_q[i][AW+15:16], obs_q[i][15:0], exp_q[i][AW+15:16], exp_q[i][15:0]);
      end
    end
    checks++;
    if (short_f !== 1'b1) begin errors++; $display("FAIL short_flag_set: got %b expected 1", short_f); end
    checks++;
    if (done_cnt != d0 + 1) begin errors++; $display("FAIL short_done_count: got %0d expected 1", done_cnt - d0); end
    pulse_req();
    checks++;
    if (short_f !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL short_clear_on_arm: short=%b busy=%b expected short=0 busy=1", short_f, busy);
    end
    exp_q.delete(); obs_q.delete();
    drive_frame(V, 0, 1'b0, ry);
    wait_done("short_followup", seen);
    repeat (3) tick();
    last_exp = V * H - 1;
    checks++;
    if (obs_q.size() != V * H || obs_q[obs_q.size() - 1][AW+15:16] != AW'(last_exp)) begin
      errors++;
      $display("FAIL short_followup_writes: got count %0d expected %0d ending at addr %0d",
               obs_q.size(), V * H, last_exp);
    end
  endtask

  task automatic test_arm_midframe();
    int ry, dummy, d0;
    bit seen;
    exp_q.delete(); obs_q.delete(); d0 = done_cnt;
    vsync = 1'b0;
    tick();
    pulse_req();
    model_on = 1'b0;
    dummy = 0;
    drive_row(H, dummy);
    drive_row(5, dummy);
    checks++;
    if (obs_q.size() != 0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL midframe_no_write: got %0d writes busy=%b expected 0 writes busy=1", obs_q.size(), busy);
    end
    model_on = 1'b1;
    vsync = 1'b1;
    repeat (3) tick();
    drive_frame(V, 2, 1'b1, ry);
    wait_done("midframe", seen);
    if (seen) begin
      capture_req = 1'b1;
      repeat (4) tick();
      capture_req = 1'b0;
      tick();
    end
    repeat (2) tick();
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL midframe_write_count: got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL midframe_write[%0d]: got addr=%0d data=%h expected addr=%0d data=%h",
                 i, obs_q[i][AW+15:16], obs_q[i][15:0], exp_q[i][AW+15:16], exp_q[i][15:0]);
      end
    end
    checks++;
    if (done_cnt != d0 + 1) begin errors++; $display("FAIL midframe_done_count: got %0d expected 1", done_cnt - d0); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL midframe_req_ignored: busy got %b expected 0", busy); end
    checks++;
    if (short_f !== (ry < V)) begin errors++; $display("FAIL midframe_short: got %b expected %b", short_f, ry < V); end
  endtask

  task automatic test_reset_midcapture();
    int ry, d0;
    bit seen;
    exp_q.delete(); obs_q.delete(); d0 = done_cnt; model_on = 1'b1;
    vsync = 1'b1;
    tick();
    pulse_req();
    vsync = 1'b0;
    repeat (3) tick();
    ry = 0;
    for (int r = 0; r < 3; r++) drive_row(H, ry);
    href = 1'b1;
    tick();
    pvalid = 1'b1;
    pdata = 16'($urandom);
    tick();
    pvalid = 1'b0;
    #2;
    checks++;
    if (bram_we !== 1'b1) begin errors++; $display("FAIL rstmid_we_before: got %b expected 1", bram_we); end
    rst = 1'b1;
    #1;
    checks++;
    if (bram_we !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_async: we=%b busy=%b expected 0 and 0", bram_we, busy);
    end
    href = 1'b0;
    vsync = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    repeat (3) tick();
    checks++;
    if (done_cnt != d0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_no_done: done pulses %0d busy=%b expected 0 and 0", done_cnt - d0, busy);
    end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL rstmid_pre_writes: got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    exp_q.delete(); obs_q.delete();
    pulse_req();
    drive_frame(V, 0, 1'b0, ry);
    wait_done("rstmid_recapture", seen);
    repeat (3) tick();
    checks++;
    if (obs_q.size() != V * H) begin
      errors++;
      $display("FAIL rstmid_recapture_count: got %0d expected %0d", obs_q.size(), V * H);
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL rstmid_write[%0d]: got addr=%0d data=%h expected addr=%0d data=%h",
                 i, obs_q[i][AW+15:16], obs_q[i][15:0], exp_q[i][AW+15:16], exp_q[i][15:0]);
      end
    end
  endtask

`ifdef CAPTURE_CONT_EN
  task automatic test_continuous();
    int ry, d0;
    bit seen;
    d0 = done_cnt; model_on = 1'b1;
    vsync = 1'b1;
    tick();
    pulse_req();
    for (int f = 0; f < 3; f++) begin
      exp_q.delete(); obs_q.delete();
      drive_frame(V, 1, 1'b0, ry);
      wait_done("continuous", seen);
      repeat (3) tick();
      checks++;
      if (obs_q.size() != exp_q.size() || obs_q.size() == 0 || obs_q[0][AW+15:16] != '0) begin
        errors++;
        $display("FAIL cont_frame%0d_writes: got %0d writes expected %0d starting at addr 0",
                 f, obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL cont_write[%0d]: got addr=%0d data=%h expected addr=%0d data=%h",
                   i, obs_q[i][AW+15:16], obs_q[i][15:0], exp_q[i][AW+15:16], exp_q[i][15:0]);
        end
      end
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL cont_rearmed: busy got %b expected 1", busy); end
    end
    checks++;
    if (done_cnt != d0 + 3) begin errors++; $display("FAIL cont_done_count: got %0d expected 3", done_cnt - d0); end
  endtask
`endif

  initial begin
    test_reset();
`ifdef CAPTURE_CONT_EN
    test_continuous();
`else
    test_full_frame();
    test_long_rows();
    test_short_frame();
    test_arm_midframe();
    test_reset_midcapture();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
